phy_lane_collector: RTL and testbench

Receive-side unstriping stage that sits directly downstream of the PHY receiver outputs. It captures the four 8-bit lane bytes qualified by per-lane valid bits into four per-lane FIFOs. It then re-serialises them in strict lane order 0→1→2→3→0 onto a single byte stream with a valid/ready handshake. This restores the byte order the transmitter striped across the lanes and gives the consumer backpressure, which the PHY itself cannot absorb.

---
 rtl/phy_lane_collector_pkg.sv | 20 ++
 rtl/phy_lane_fifo.sv | 48 ++++
 rtl/phy_lane_collector.sv | 116 +++++++++++
 tb/tb_phy_lane_collector.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_lane_collector_pkg.sv
// Shared PHY receive-side constants and types for the lane collector.
package phy_lane_collector_pkg;

  localparam int PHY_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int BYTE_W    = 8;

  // 8b/10b control symbols used across the PHY (K28.5 comma, K28.3 idle)
  localparam logic [BYTE_W-1:0] SYM_COM  = 8'hBC;
  localparam logic [BYTE_W-1:0] SYM_IDLE = 8'h7C;

  typedef logic [LANE_W-1:0] lane_idx_t;
  typedef logic [BYTE_W-1:0] phy_byte_t;

  // Round-robin successor; lane 3 wraps back to lane 0.
  function automatic lane_idx_t lane_next(input lane_idx_t l);
    return lane_idx_t'(l + 1'b1);
  endfunction

endpackage

// File: rtl/phy_lane_fifo.sv
// Single-lane byte FIFO with wrap-bit pointers. The caller decides whether a
// push is legal; full and empty are derived purely from the pointer registers.
module phy_lane_fifo
  import phy_lane_collector_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk4f,
  input  logic      reset,
  input  logic      flush,
  input  logic      push,
  input  phy_byte_t din,
  input  logic      pop,
  output phy_byte_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  phy_byte_t   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk4f) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/phy_lane_collector.sv
// Receive-side unstriper: four lane FIFOs drained strictly in lane order
// 0,1,2,3,0... onto one byte stream. Optional statistics counters are built
// when PHY_COLLECT_STATS_EN is defined.
//
// Output handshake: a byte transfers on a rising edge where valid_out and
// ready_in are both high. While valid_out is high and ready_in is low,
// data_out and lane_out hold. The output register reloads whenever it is
// empty or being accepted and the current lane has data; it never skips an
// empty lane.
module phy_lane_collector
  import phy_lane_collector_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk4f,
  input  logic        reset,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  input  logic [3:0]  validin,
  input  logic        flush,
  output logic [7:0]  data_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [1:0]  lane_out,
  output logic [3:0]  full,
  output logic [3:0]  overflow
`ifdef PHY_COLLECT_STATS_EN
  ,
  output logic [15:0] byte_count,
  output logic [7:0]  drop_count
`endif
);

  lane_idx_t       next_lane;
  phy_byte_t       lane_din  [PHY_LANES];
  phy_byte_t       lane_dout [PHY_LANES];
  logic [3:0]      lane_empty;
  logic [3:0]      lane_push;
  logic [3:0]      lane_pop;
  logic [3:0]      lane_drop;
  logic            load;

  assign lane_din[0] = in0;
  assign lane_din[1] = in1;
  assign lane_din[2] = in2;
  assign lane_din[3] = in3;

  // Output register may take a new byte only from the lane the pointer names.
  assign load = !flush && (!valid_out || ready_in) && !lane_empty[next_lane];

  for (genvar k = 0; k < PHY_LANES; k++) begin : g_lane
    // A full lane still accepts a push when it is being popped this cycle.
    assign lane_pop[k]  = load && (next_lane == lane_idx_t'(k));
    assign lane_push[k] = validin[k] && !flush && (!full[k] || lane_pop[k]);
    assign lane_drop[k] = validin[k] && !flush && full[k] && !lane_pop[k];

    phy_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk4f (clk4f),
      .reset (reset),
      .flush (flush),
      .push  (lane_push[k]),
      .din   (lane_din[k]),
      .pop   (lane_pop[k]),
      .dout  (lane_dout[k]),
      .full  (full[k]),
      .empty (lane_empty[k])
    );
  end

  // Output register and lane pointer: load, hold under backpressure, or drain.
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= '0;
      next_lane <= '0;
    end else if (flush) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= '0;
      next_lane <= '0;
    end else if (load) begin
      data_out  <= lane_dout[next_lane];
      lane_out  <= next_lane;
      valid_out <= 1'b1;
      next_lane <= lane_next(next_lane);
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

  // Sticky per-lane drop flags.
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset)      overflow <= '0;
    else if (flush) overflow <= '0;
    else            overflow <= overflow | lane_drop;
  end

`ifdef PHY_COLLECT_STATS_EN
  // Saturating statistics; cleared by reset only so they survive a flush.
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      drop_count <= '0;
    end else begin
      if (valid_out && ready_in && (byte_count != 16'hFFFF))
        byte_count <= byte_count + 16'd1;
      if ((|lane_drop) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phy_lane_collector.sv
// Bench for phy_lane_collector: reset check, vector table, hand sequences for
// backpressure/overflow/full-with-pop/flush/reset, then random traffic. A
// queue-based model tracks every cycle and is compared after each edge.
module tb_phy_lane_collector;

  localparam int DEPTH = 8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk4f;
  logic        reset;
  logic [7:0]  in0, in1, in2, in3;
  logic [3:0]  validin;
  logic        flush;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in;
  logic [1:0]  lane_out;
  logic [3:0]  full;
  logic [3:0]  overflow;
`ifdef PHY_COLLECT_STATS_EN
  logic [15:0] byte_count;
  logic [7:0]  drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  initial clk4f = 1'b0;
  always #5 clk4f = ~clk4f;

  phy_lane_collector #(.DEPTH(DEPTH)) dut (
    .clk4f     (clk4f),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .validin   (validin),
    .flush     (flush),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .lane_out  (lane_out),
    .full      (full),
    .overflow  (overflow)
`ifdef PHY_COLLECT_STATS_EN
    ,
    .byte_count(byte_count),
    .drop_count(drop_count)
`endif
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (queues per lane) ----------------
  logic [7:0] mq [4][$];
  int         m_nl    = 0;
  logic       m_vo    = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic [1:0] m_lane  = 2'd0;
  logic [3:0] m_ovf   = 4'h0;
  logic [3:0] m_full  = 4'h0;
  int         m_bytes = 0;
  int         m_drops = 0;
  bit         m_ld;
  bit         m_any;

  function automatic logic [7:0] lane_byte(input int k);
    case (k)
      0:       return in0;
      1:       return in1;
      2:       return in2;
      default: return in3;
    endcase
  endfunction

  always @(posedge clk4f) begin
    if (!reset && m_vo && ready_in && m_bytes < 65535) m_bytes++;
    if (reset) begin
      m_bytes = 0;
      m_drops = 0;
    end
    if (reset || flush) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
      m_nl = 0; m_vo = 1'b0; m_data = 8'h00; m_lane = 2'd0; m_ovf = 4'h0;
    end else begin
      m_ld = (!m_vo || ready_in) && (mq[m_nl].size() > 0);
      if (m_ld) begin
        m_data = mq[m_nl].pop_front();
        m_lane = 2'(m_nl);
        m_vo   = 1'b1;
        m_nl   = (m_nl + 1) % 4;
      end else if (ready_in) begin
        m_vo = 1'b0;
      end
      m_any = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (validin[k]) begin
          if (mq[k].size() < DEPTH) mq[k].push_back(lane_byte(k));
          else begin
            m_ovf[k] = 1'b1;
            m_any    = 1'b1;
          end
        end
      end
      if (m_any && m_drops < 255) m_drops++;
    end
    for (int k = 0; k < 4; k++) m_full[k] = (mq[k].size() == DEPTH);
    #1;
    check("model vo/data/lane/full/ovf",
          {13'd0, valid_out, data_out, lane_out, full, overflow},
          {13'd0, m_vo, m_data, m_lane, m_full, m_ovf});
`ifdef PHY_COLLECT_STATS_EN
    check("model byte_count", byte_count, m_bytes);
    check("model drop_count", drop_count, m_drops);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk4f);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] b, input logic r);
    validin  = v;
    in0      = b[7:0];
    in1      = b[15:8];
    in2      = b[23:16];
    in3      = b[31:24];
    ready_in = r;
  endtask

  // Wait (bounded) for a presented byte, check it; it is consumed at the next edge.
  task automatic wait_out(input string name, input logic [7:0] ed, input logic [1:0] el);
    int n;
    n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    check({name, " valid"}, valid_out, 1);
    check({name, " data"}, data_out, ed);
    check({name, " lane"}, lane_out, el);
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  vin;
    logic [31:0] bytes;
    logic        rdy;
    logic        fl;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  el;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] b, input logic fl,
                              input logic ev, input logic [7:0] ed, input logic [1:0] el);
    vec_t t;
    t.vin = v; t.bytes = b; t.rdy = 1'b1; t.fl = fl; t.ev = ev; t.ed = ed; t.el = el;
    return t;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(4'h0, 32'h0, 1'b0);

    // reset state
    tick(); tick();
    check("reset valid_out", valid_out, 0);
    check("reset data_out", data_out, 0);
    check("reset lane_out", lane_out, 0);
    check("reset full", full, 0);
    check("reset overflow", overflow, 0);
`ifdef PHY_COLLECT_STATS_EN
    check("reset byte_count", byte_count, 0);
    check("reset drop_count", drop_count, 0);
`endif
    reset = 1'b0;

    // single lane, then flush, then strict lane ordering 3,2,1,0 pushes
    tbl[0]  = mk(4'b0001, 32'h0000_00A0, 0, 0, 8'h00, 2'd0);
    tbl[1]  = mk(4'b0000, 32'h0,         0, 1, 8'hA0, 2'd0);
    tbl[2]  = mk(4'b0000, 32'h0,         0, 0, 8'h00, 2'd0);
    tbl[3]  = mk(4'b0000, 32'h0,         1, 0, 8'h00, 2'd0);
    tbl[4]  = mk(4'b1000, 32'h1100_0000, 0, 0, 8'h00, 2'd0);
    tbl[5]  = mk(4'b0100, 32'h0022_0000, 0, 0, 8'h00, 2'd0);
    tbl[6]  = mk(4'b0010, 32'h0000_3300, 0, 0, 8'h00, 2'd0);
    tbl[7]  = mk(4'b0001, 32'h0000_0044, 0, 0, 8'h00, 2'd0);
    tbl[8]  = mk(4'b0000, 32'h0,         0, 1, 8'h44, 2'd0);
    tbl[9]  = mk(4'b0000, 32'h0,         0, 1, 8'h33, 2'd1);
    tbl[10] = mk(4'b0000, 32'h0,         0, 1, 8'h22, 2'd2);
    tbl[11] = mk(4'b0000, 32'h0,         0, 1, 8'h11, 2'd3);
    tbl[12] = mk(4'b0000, 32'h0,         0, 0, 8'h00, 2'd0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].vin, tbl[i].bytes, tbl[i].rdy);
      flush = tbl[i].fl;
      tick();
      check($sformatf("tbl[%0d] valid", i), valid_out, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("tbl[%0d] data", i), data_out, tbl[i].ed);
        check($sformatf("tbl[%0d] lane", i), lane_out, tbl[i].el);
      end
      check($sformatf("tbl[%0d] full", i), full, 0);
      check($sformatf("tbl[%0d] ovf", i), overflow, 0);
    end
    flush = 1'b0;

    // backpressure: 0x55 held for 5 cycles while more bytes arrive
    drive(4'b0001, 32'h0000_0055, 1'b0); tick();
    drive(4'b0000, 32'h0, 1'b0); tick();
    check("bp first valid", valid_out, 1);
    check("bp first data", data_out, 8'h55);
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(4'b0010, 32'h0000_6600, 1'b0);
      else if (i == 1) drive(4'b0100, 32'h0067_0000, 1'b0);
      else             drive(4'b0000, 32'h0, 1'b0);
      tick();
      check($sformatf("bp hold%0d valid", i), valid_out, 1);
      check($sformatf("bp hold%0d data", i), data_out, 8'h55);
      check($sformatf("bp hold%0d lane", i), lane_out, 0);
    end
    drive(4'b0000, 32'h0, 1'b1); tick();
    check("bp release data", data_out, 8'h66);
    check("bp release lane", lane_out, 1);
    tick();
    check("bp next data", data_out, 8'h67);
    tick();
    check("bp lane3 empty valid", valid_out, 0);
    flush = 1'b1; tick(); flush = 1'b0;

    // overflow: lane 1 pushed DEPTH+2 times with no lane-0 data and ready low
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(4'b0010, {16'h0, 8'(8'h80 + i), 8'h00}, 1'b0);
      tick();
      if (i == DEPTH - 2) check("ovf full before 8", full[1], 0);
      if (i == DEPTH - 1) begin
        check("ovf full after 8", full[1], 1);
        check("ovf not yet", overflow[1], 0);
      end
    end
    check("ovf flag", overflow, 4'b0010);
    check("ovf full", full, 4'b0010);
`ifdef PHY_COLLECT_STATS_EN
    check("ovf drop_count", drop_count, 2);
`endif
    for (int r = 0; r < 8; r++) begin
      drive(4'b1101, {8'(8'h30 + r), 8'(8'h20 + r), 8'h00, 8'(r)}, 1'b0);
      tick();
    end
    drive(4'b0000, 32'h0, 1'b1);
    for (int r = 0; r < 8; r++) begin
      wait_out($sformatf("ovf drain r%0d l0", r), 8'(r), 2'd0);
      wait_out($sformatf("ovf drain r%0d l1", r), 8'(8'h80 + r), 2'd1);
      wait_out($sformatf("ovf drain r%0d l2", r), 8'(8'h20 + r), 2'd2);
      wait_out($sformatf("ovf drain r%0d l3", r), 8'(8'h30 + r), 2'd3);
    end
    check("ovf sticky", overflow[1], 1);

    // full lane 0 with a pop in the same cycle as a push
    drive(4'b1111, 32'hE3E2_E1E0, 1'b1); tick();
    drive(4'b0000, 32'h0, 1'b1);
    begin
      int n;
      n = 0;
      while (!(valid_out && lane_out == 2'd3) && n < 10) begin
        tick();
        n++;
      end
    end
    ready_in = 1'b0;
    check("fp lane3 held", {valid_out, data_out}, {1'b1, 8'hE3});
    for (int i = 0; i < DEPTH; i++) begin
      drive(4'b0001, {24'h0, 8'(8'h90 + i)}, 1'b0);
      tick();
    end
    check("fp lane0 full", full[0], 1);
    check("fp no ovf before", overflow[0], 0);
    drive(4'b0001, 32'h0000_0077, 1'b1); tick();
    check("fp no ovf", overflow[0], 0);
    check("fp still full", full[0], 1);
    check("fp load data", data_out, 8'h90);
    check("fp load lane", lane_out, 0);
    for (int r = 0; r < 8; r++) begin
      drive(4'b1110, {8'(8'hD0 + r), 8'(8'hC0 + r), 8'(8'hB0 + r), 8'h00}, 1'b0);
      tick();
    end
    drive(4'b0000, 32'h0, 1'b1);
    for (int r = 0; r < 8; r++) begin
      wait_out($sformatf("fp r%0d l0", r), 8'(8'h90 + r), 2'd0);
      wait_out($sformatf("fp r%0d l1", r), 8'(8'hB0 + r), 2'd1);
      wait_out($sformatf("fp r%0d l2", r), 8'(8'hC0 + r), 2'd2);
      wait_out($sformatf("fp r%0d l3", r), 8'(8'hD0 + r), 2'd3);
    end
    wait_out("fp retained 77", 8'h77, 2'd0);

    // flush mid-stream with data in all lanes and overflow[1] still set
    drive(4'b1111, 32'hF3F2_F1F0, 1'b0); tick(); tick();
    check("fl pre valid", valid_out, 1);
    check("fl pre ovf", overflow[1], 1);
    drive(4'b0000, 32'h0, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl valid", valid_out, 0);
    check("fl full", full, 0);
    check("fl ovf", overflow, 0);
    check("fl next_lane", dut.next_lane, 0);
`ifdef PHY_COLLECT_STATS_EN
    check("fl byte_count kept", byte_count, m_bytes);
    check("fl byte_count nonzero", byte_count == 16'd0, 0);
`endif
    ready_in = 1'b1; tick(); tick();
    check("fl stays empty", valid_out, 0);

    // asynchronous reset with valid_out high
    drive(4'b0101, 32'h0010_005A, 1'b0); tick();
    for (int i = 1; i < DEPTH + 1; i++) begin
      drive(4'b0100, {8'h00, 8'(8'h10 + i), 16'h0}, 1'b0);
      tick();
    end
    check("rst pre valid", {valid_out, data_out}, {1'b1, 8'h5A});
    check("rst pre ovf", overflow, 4'b0100);
    drive(4'b0000, 32'h0, 1'b0);
    #3 reset = 1'b1;
    #1;
    check("rst async valid", valid_out, 0);
    check("rst async full", full, 0);
    check("rst async ovf", overflow, 0);
    check("rst async next_lane", dut.next_lane, 0);
`ifdef PHY_COLLECT_STATS_EN
    check("rst byte_count", byte_count, 0);
`endif
    tick();
    reset = 1'b0;
    ready_in = 1'b1;
    tick();
    check("rst after valid", valid_out, 0);

    // random traffic: light, saturating, mixed phases
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] v;
      if (c < 1000)      v = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      else if (c < 2000) v = 4'hF;
      else               v = 4'($urandom_range(0, 15));
      drive(v, $urandom, ($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 99) == 0);
      tick();
    end
    flush = 1'b0;
    drive(4'b0000, 32'h0, 1'b1);
    tick();
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
